// File: rtl/lock_mem_client_if.sv
// Bundle of core-side request/response, lock-arbiter and RAM-port signals
// for one lock_mem_client. The master modport is the client itself; the
// slave modport is whatever surrounds it (core, arbiter and RAM glue).
interface lock_mem_client_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              lock_self;
  logic              lock_peer;
  logic              need_lock;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data;
  logic              mem_wren;
  logic [31:0]       mem_q;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  lock_self, lock_peer, mem_q,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output need_lock, mem_address, mem_data, mem_wren
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output lock_self, lock_peer, mem_q,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  need_lock, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/lock_mem_client.sv
// Initiator side of the shared-memory lock protocol. Takes one load/store
// from the core, requests the lock, performs the access on its RAM port
// once granted, replays the access if the arbiter preempts it, and gives
// up with an error response if the grant never arrives.
module lock_mem_client #(
  parameter int ADDR_W        = 6,
  parameter int RD_LATENCY    = 2,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  lock_mem_client_if.master     bus,
  output logic                  timeout_err,
  output logic [7:0]            retry_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACCESS,
    WAIT,
    RELEASE
  } state_t;

  // Timeout fires on the edge where the wait counter would reach the limit.
  localparam logic [7:0] TimeoutLast = 8'(GRANT_TIMEOUT - 1);
  localparam logic [1:0] ReadLast    = 2'(RD_LATENCY);

  state_t            r_state;
  logic              r_we;
  logic [7:0]        r_waitCnt;
  logic [1:0]        r_latCnt;
  logic              r_reqReady;
  logic              r_rspValid;
  logic              r_rspErr;
  logic [31:0]       r_rspRdata;
  logic              r_needLock;
  logic [ADDR_W-1:0] r_memAddress;
  logic [31:0]       r_memData;
  logic              r_timeoutErr;
  logic [7:0]        r_retryCnt;

  logic w_grant;
  logic w_preempt;

  // Grant means the arbiter stalled the peer and not us.
  assign w_grant   = bus.lock_peer && !bus.lock_self;
  assign w_preempt = bus.lock_self;

  assign bus.req_ready   = r_reqReady;
  assign bus.rsp_valid   = r_rspValid;
  assign bus.rsp_err     = r_rspErr;
  assign bus.rsp_rdata   = r_rspRdata;
  assign bus.need_lock   = r_needLock;
  assign bus.mem_address = r_memAddress;
  assign bus.mem_data    = r_memData;
  // Write strobe is gated by lock_self directly so a late preemption can
  // never let a store through while this core is stalled.
  assign bus.mem_wren    = (r_state == ACCESS) && r_we && !bus.lock_self;
  assign timeout_err     = r_timeoutErr;
  assign retry_cnt       = r_retryCnt;

  // Protocol state machine with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_waitCnt    <= 8'd0;
      r_latCnt     <= 2'd0;
      r_reqReady   <= 1'b1;
      r_rspValid   <= 1'b0;
      r_rspErr     <= 1'b0;
      r_rspRdata   <= 32'd0;
      r_needLock   <= 1'b0;
      r_memAddress <= '0;
      r_memData    <= 32'd0;
      r_timeoutErr <= 1'b0;
      r_retryCnt   <= 8'd0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we         <= bus.req_we;
            r_memAddress <= bus.req_addr;
            r_memData    <= bus.req_wdata;
            r_needLock   <= 1'b1;
            r_waitCnt    <= 8'd0;
            r_reqReady   <= 1'b0;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (w_grant) begin
            r_state <= ACCESS;
          end else if (r_waitCnt == TimeoutLast) begin
            r_timeoutErr <= 1'b1;
            r_rspValid   <= 1'b1;
            r_rspErr     <= 1'b1;
            r_needLock   <= 1'b0;
            r_state      <= RELEASE;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        ACCESS, WAIT: begin
          if (w_preempt) begin
            // Abandon this attempt; the whole access is replayed after regrant.
            r_waitCnt <= 8'd0;
            if (r_retryCnt != 8'hFF) begin
              r_retryCnt <= r_retryCnt + 8'd1;
            end
            r_state <= REQ;
          end else if (r_state == ACCESS) begin
            if (r_we) begin
              r_rspValid <= 1'b1;
              r_needLock <= 1'b0;
              r_state    <= RELEASE;
            end else begin
              r_latCnt <= 2'd1;
              r_state  <= WAIT;
            end
          end else if (r_latCnt == ReadLast) begin
            r_rspRdata <= bus.mem_q;
            r_rspValid <= 1'b1;
            r_needLock <= 1'b0;
            r_state    <= RELEASE;
          end else begin
            r_latCnt <= r_latCnt + 2'd1;
          end
        end
        RELEASE: begin
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_needLock <= 1'b0;
          r_reqReady <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_mem_client.sv
// Bench for lock_mem_client: two clients sharing a dual-port RAM through a
// registered lock arbiter model, with an override on core0's lock inputs to
// create preemption and starvation. Expected responses go into per-core
// queues when a request is issued and are compared when rsp_valid appears.
module tb_lock_mem_client;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ovr;
  logic        ovrSelf;
  logic        ovrPeer;
  logic [1:0]  arbLock;
  logic        timeoutErr0;
  logic        timeoutErr1;
  logic [7:0]  retryCnt0;
  logic [7:0]  retryCnt1;

  int          errors;
  int          checks;
  int          cyc;
  int          rspCnt0;
  int          rspCnt1;
  int          wrenCnt0;
  int          bothWren;
  logic [5:0]  lastWrAddr0;
  logic [31:0] lastWrData0;
  int          reqEdge [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  logic [31:0] ram [0:63];
  logic [31:0] q0a, q0b, q1a, q1b;

  lock_mem_client_if #(.ADDR_W(6)) bus0 ();
  lock_mem_client_if #(.ADDR_W(6)) bus1 ();

  lock_mem_client #(.ADDR_W(6), .RD_LATENCY(2), .GRANT_TIMEOUT(15)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .timeout_err(timeoutErr0), .retry_cnt(retryCnt0)
  );

  lock_mem_client #(.ADDR_W(6), .RD_LATENCY(2), .GRANT_TIMEOUT(15)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .timeout_err(timeoutErr1), .retry_cnt(retryCnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered arbiter: bit0 stalls core0, bit1 stalls core1; core0 wins ties.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      arbLock <= 2'b00;
    end else begin
      case (arbLock)
        2'b00:   if (bus0.need_lock) arbLock <= 2'b10;
                 else if (bus1.need_lock) arbLock <= 2'b01;
        2'b10:   if (!bus0.need_lock) arbLock <= 2'b00;
        2'b01:   if (!bus1.need_lock) arbLock <= 2'b00;
        default: arbLock <= 2'b00;
      endcase
    end
  end

  assign bus0.lock_self = ovr ? ovrSelf : arbLock[0];
  assign bus0.lock_peer = ovr ? ovrPeer : arbLock[1];
  assign bus1.lock_self = arbLock[1];
  assign bus1.lock_peer = arbLock[0];

  // Dual-port RAM with a two-stage read pipeline on each port.
  always @(posedge clk) begin
    if (bus0.mem_wren === 1'b1) ram[bus0.mem_address] <= bus0.mem_data;
    if (bus1.mem_wren === 1'b1) ram[bus1.mem_address] <= bus1.mem_data;
    q0a <= ram[bus0.mem_address];
    q0b <= q0a;
    q1a <= ram[bus1.mem_address];
    q1b <= q1a;
  end

  assign bus0.mem_q = q0b;
  assign bus1.mem_q = q1b;

  // Cycle counter and activity monitors, sampled at the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus0.rsp_valid === 1'b1) rspCnt0 <= rspCnt0 + 1;
    if (bus1.rsp_valid === 1'b1) rspCnt1 <= rspCnt1 + 1;
    if (bus0.mem_wren === 1'b1) begin
      wrenCnt0    <= wrenCnt0 + 1;
      lastWrAddr0 <= bus0.mem_address;
      lastWrData0 <= bus0.mem_data;
    end
    if (bus0.mem_wren === 1'b1 && bus1.mem_wren === 1'b1) bothWren <= bothWren + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the next posedge is the request edge.
  task automatic applyStimulus(input int core, input logic we, input logic [5:0] addr,
                               input logic [31:0] wdata);
    reqEdge[core] = cyc + 1;
    if (core == 0) begin
      bus0.req_we = we; bus0.req_addr = addr; bus0.req_wdata = wdata; bus0.req_valid = 1'b1;
    end else begin
      bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_valid = 1'b1;
    end
  endtask

  task automatic pushExp(input int core, input logic err, input logic chk, input logic [31:0] data);
    exp_t e;
    e.err = err; e.chk = chk; e.data = data;
    if (core == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic serviceRsp(input int core, output bit seen, output int lat);
    logic        vld;
    logic        err;
    logic [31:0] d;
    exp_t        e;
    int          qs;
    vld  = (core == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    err  = (core == 0) ? bus0.rsp_err : bus1.rsp_err;
    d    = (core == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    seen = 1'b0;
    lat  = 0;
    if (vld === 1'b1) begin
      seen = 1'b1;
      lat  = cyc - reqEdge[core];
      qs   = (core == 0) ? q0.size() : q1.size();
      checkOutput($sformatf("rsp_expected_c%0d", core), 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        e = (core == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput($sformatf("rsp_err_c%0d", core), 32'(err), 32'(e.err));
        if (e.chk) checkOutput($sformatf("rsp_rdata_c%0d", core), d, e.data);
      end
      if (core == 0) bus0.req_valid = 1'b0;
      else bus1.req_valid = 1'b0;
    end
  endtask

  task automatic waitRsp(input int core, input int budget, output int lat);
    bit seen;
    int l;
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      serviceRsp(core, seen, l);
      if (seen) lat = l;
    end
    checkOutput($sformatf("rsp_seen_c%0d", core), 32'(seen), 32'd1);
  endtask

  initial begin
    int lat, lat1, l;
    int sW, sR0, sR1, sBoth;
    bit d0, d1, sn;

    rst = 1'b0;
    ovr = 1'b0; ovrSelf = 1'b0; ovrPeer = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready",   32'(bus0.req_ready),   32'd1);
    checkOutput("rst_need_lock",   32'(bus0.need_lock),   32'd0);
    checkOutput("rst_mem_wren",    32'(bus0.mem_wren),    32'd0);
    checkOutput("rst_rsp_valid",   32'(bus0.rsp_valid),   32'd0);
    checkOutput("rst_timeout_err", 32'(timeoutErr0),      32'd0);
    checkOutput("rst_retry_cnt",   32'(retryCnt0),        32'd0);
    checkOutput("rst_mem_address", 32'(bus0.mem_address), 32'd0);
    checkOutput("rst_rsp_rdata",   bus0.rsp_rdata,        32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(bus0.req_ready), 32'd1);

    // Uncontended store
    @(negedge clk);
    sW = wrenCnt0; sR0 = rspCnt0;
    applyStimulus(0, 1'b1, 6'h05, 32'hDEADBEEF);
    pushExp(0, 1'b0, 1'b0, 32'd0);
    waitRsp(0, 20, lat);
    checkOutput("store_latency", 32'(lat), 32'd3);
    checkOutput("store_need_lock_drop", 32'(bus0.need_lock), 32'd0);
    @(negedge clk);
    checkOutput("store_req_ready_back", 32'(bus0.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("store_wren_cycles", 32'(wrenCnt0 - sW), 32'd1);
    checkOutput("store_wr_addr", 32'(lastWrAddr0), 32'h05);
    checkOutput("store_wr_data", lastWrData0, 32'hDEADBEEF);
    checkOutput("store_ram", ram[5], 32'hDEADBEEF);
    checkOutput("store_rsp_count", 32'(rspCnt0 - sR0), 32'd1);

    // Uncontended load
    @(negedge clk);
    sW = wrenCnt0;
    applyStimulus(0, 1'b0, 6'h05, 32'd0);
    pushExp(0, 1'b0, 1'b1, 32'hDEADBEEF);
    waitRsp(0, 20, lat);
    checkOutput("load_latency", 32'(lat), 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("load_no_wren", 32'(wrenCnt0 - sW), 32'd0);

    // Simultaneous stores from both cores
    @(negedge clk);
    sR0 = rspCnt0; sR1 = rspCnt1; sBoth = bothWren;
    applyStimulus(0, 1'b1, 6'h01, 32'h11);
    applyStimulus(1, 1'b1, 6'h02, 32'h22);
    pushExp(0, 1'b0, 1'b0, 32'd0);
    pushExp(1, 1'b0, 1'b0, 32'd0);
    d0 = 1'b0; d1 = 1'b0; lat1 = -1;
    for (int i = 0; i < 40 && !(d0 && d1); i++) begin
      @(negedge clk);
      serviceRsp(0, sn, l);
      if (sn) d0 = 1'b1;
      serviceRsp(1, sn, l);
      if (sn) begin d1 = 1'b1; lat1 = l; end
    end
    checkOutput("dual_seen_c0", 32'(d0), 32'd1);
    checkOutput("dual_seen_c1", 32'(d1), 32'd1);
    checkOutput("dual_latency_c1", 32'(lat1), 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("dual_no_overlap", 32'(bothWren - sBoth), 32'd0);
    checkOutput("dual_ram1", ram[1], 32'h11);
    checkOutput("dual_ram2", ram[2], 32'h22);
    checkOutput("dual_rsp_count_c0", 32'(rspCnt0 - sR0), 32'd1);
    checkOutput("dual_rsp_count_c1", 32'(rspCnt1 - sR1), 32'd1);

    // Preemption during WAIT of a load
    @(negedge clk);
    sR0 = rspCnt0;
    applyStimulus(0, 1'b0, 6'h02, 32'd0);
    pushExp(0, 1'b0, 1'b1, 32'h22);
    repeat (4) @(negedge clk);
    ovr = 1'b1; ovrSelf = 1'b1; ovrPeer = 1'b0;
    @(negedge clk);
    checkOutput("preempt_retry_cnt", 32'(retryCnt0), 32'd1);
    checkOutput("preempt_need_lock_held", 32'(bus0.need_lock), 32'd1);
    checkOutput("preempt_no_rsp", 32'(bus0.rsp_valid), 32'd0);
    ovr = 1'b0; ovrSelf = 1'b0;
    waitRsp(0, 30, lat);
    checkOutput("preempt_latency", 32'(lat), 32'd8);
    repeat (3) @(negedge clk);
    checkOutput("preempt_rsp_count", 32'(rspCnt0 - sR0), 32'd1);
    checkOutput("preempt_retry_final", 32'(retryCnt0), 32'd1);

    // Grant starvation
    @(negedge clk);
    ovr = 1'b1; ovrSelf = 1'b0; ovrPeer = 1'b0;
    sW = wrenCnt0;
    applyStimulus(0, 1'b1, 6'h03, 32'h33);
    pushExp(0, 1'b1, 1'b0, 32'd0);
    waitRsp(0, 40, lat);
    checkOutput("starve_latency", 32'(lat), 32'd15);
    checkOutput("starve_timeout_err", 32'(timeoutErr0), 32'd1);
    checkOutput("starve_need_lock_drop", 32'(bus0.need_lock), 32'd0);
    ovr = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("starve_no_wren", 32'(wrenCnt0 - sW), 32'd0);

    // Store after timeout proceeds normally while the flag stays set
    applyStimulus(0, 1'b1, 6'h03, 32'h33);
    pushExp(0, 1'b0, 1'b0, 32'd0);
    waitRsp(0, 20, lat);
    checkOutput("after_starve_latency", 32'(lat), 32'd3);
    repeat (2) @(negedge clk);
    checkOutput("after_starve_ram3", ram[3], 32'h33);
    checkOutput("timeout_err_sticky", 32'(timeoutErr0), 32'd1);

    // Reset in the middle of a load
    @(negedge clk);
    sR0 = rspCnt0;
    applyStimulus(0, 1'b0, 6'h01, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_need_lock", 32'(bus0.need_lock), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus0.req_ready), 32'd1);
    checkOutput("midrst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("midrst_timeout_err", 32'(timeoutErr0), 32'd0);
    checkOutput("midrst_retry_cnt", 32'(retryCnt0), 32'd0);
    bus0.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_rsp", 32'(rspCnt0 - sR0), 32'd0);
    checkOutput("midrst_idle_ready", 32'(bus0.req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends even if a wait loop misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
